// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the button conditioner: the per-channel
// debounce state encoding and the counter-width rule used by every counter.
package btn_cond_pkg;

  // Debounce FSM states. The two stable states hold the committed level.
  // The two pending states count consecutive samples of the opposite value.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_e;

  // Width needed for a counter that must reach max_val without wrapping.
  // A width of 1 is the minimum, even for degenerate parameter values.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle between the board pins / game logic and the conditioner.
// The master drives the raw pins and consumes the conditioned outputs.
// The slave is the conditioner itself.
interface button_conditioner_if #(
  parameter int N_CH = 8
);

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_held;
  logic [N_CH-1:0] btn_repeat;
  logic            any_press;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_held,
    input  btn_repeat,
    input  any_press
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_held,
    output btn_repeat,
    output any_press
  );

endinterface

// File: rtl/button_conditioner_ch.sv
// One button channel: a 2-flop synchroniser feeds a debounce FSM.
// The FSM commits a new level only after DB_CYCLES+1 consecutive agreeing
// samples. It then emits press/release pulses, a long-press flag and
// periodic auto-repeat pulses.
module button_conditioner_ch
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES     = 500_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_held,
  output logic btn_repeat
);

  localparam int DB_W   = cnt_width(DB_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

  // Synchroniser stages; only sync_q2 is seen by the FSM.
  logic sync_q1;
  logic sync_q2;

  // Debounce FSM state and its registered outputs.
  db_state_e       state_q,  state_nxt;
  logic [DB_W-1:0] db_cnt_q, db_cnt_nxt;
  logic            level_q,  level_nxt;
  logic            press_q,  press_nxt;
  logic            release_q, release_nxt;

  // Long-press and auto-repeat bookkeeping.
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              repeat_q;
  logic              held_w;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is written with <= so every flop samples pre-edge values;
    // with = the second stage would copy the pin in the same edge and the
    // synchroniser would collapse to a single flop.
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce FSM state register and registered level/pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= STABLE_LO;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      db_cnt_q  <= db_cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
    end
  end

  // Debounce next-state logic. A mismatching sample aborts a pending change.
  // A full run of DB_CYCLES+1 agreeing samples commits it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt   = state_q;
    db_cnt_nxt  = db_cnt_q;
    level_nxt   = level_q;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync_q2) begin
          state_nxt  = PEND_HI;
          db_cnt_nxt = DB_ONE;
        end
      end
      PEND_HI: begin
        if (!sync_q2) begin
          state_nxt  = STABLE_LO;
          db_cnt_nxt = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_nxt  = STABLE_HI;
          db_cnt_nxt = '0;
          level_nxt  = 1'b1;
          press_nxt  = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt_q + DB_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_q2) begin
          state_nxt  = PEND_LO;
          db_cnt_nxt = DB_ONE;
        end
      end
      PEND_LO: begin
        if (sync_q2) begin
          state_nxt  = STABLE_HI;
          db_cnt_nxt = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_nxt   = STABLE_LO;
          db_cnt_nxt  = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_nxt  = STABLE_LO;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // The long-press flag is a pure decode of the saturated hold counter,
  // so it drops in the same cycle the counter is cleared.
  assign held_w = (hold_cnt_q == HOLD_MAX);

  // Hold counter and repeat generator.
  // A release commit clears everything in its own edge and beats a
  // coincident repeat wrap, so no repeat can follow the release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      repeat_q   <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (release_nxt) begin
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
      end else begin
        if (level_q && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_q <= hold_cnt_q + HOLD_ONE;
        end
        if ((REPEAT_EN != 0) && held_w) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + REP_ONE;
          end
        end
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_held    = held_w;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: one independent conditioner per channel, plus a
// same-cycle OR of all press pulses for "any key" menu handling.
module button_conditioner #(
  parameter int N_CH          = 8,
  parameter int DB_CYCLES     = 500_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  logic [N_CH-1:0] level_w;
  logic [N_CH-1:0] press_w;
  logic [N_CH-1:0] release_w;
  logic [N_CH-1:0] held_w;
  logic [N_CH-1:0] repeat_w;

  // One fully independent channel per button.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_conditioner_ch #(
      .DB_CYCLES     (DB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_EN)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .btn_in      (bus.btn_in[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i]),
      .btn_held    (held_w[i]),
      .btn_repeat  (repeat_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_held    = held_w;
  assign bus.btn_repeat  = repeat_w;
  assign bus.any_press   = |press_w;

endmodule
